// File: rtl/cache_set_nway.sv
// rtl/cache_set_nway.sv - WAYS-way write-back, write-allocate cache set with true-LRU replacement
module cache_set_nway #(
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 64,
  parameter int TAG_W       = 24,
  localparam int OFF_W      = $clog2(BLOCK_BYTES),
  localparam int LINE_W     = 8 * BLOCK_BYTES,
  localparam int AGE_W      = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_hit,
  output logic              resp_err,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [LINE_W-1:0] wb_data,
  output logic              fill_req,
  output logic [TAG_W-1:0]  fill_tag,
  input  logic              fill_valid,
  input  logic [LINE_W-1:0] fill_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESP} state_t;

  state_t            state_q, state_d;
  logic [WAYS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q [WAYS];
  logic [TAG_W-1:0]  tag_d [WAYS];
  logic [AGE_W-1:0]  age_q [WAYS];
  logic [AGE_W-1:0]  age_d [WAYS];
  logic [LINE_W-1:0] data_q [WAYS];
  logic [1:0]        op_q, op_d, size_q, size_d;
  logic [TAG_W-1:0]  rtag_q, rtag_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [63:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [AGE_W-1:0]  victim_q, victim_d;
  logic              resp_valid_q, resp_valid_d, hit_q, hit_d, err_q, err_d;
  logic              wb_valid_q, wb_valid_d, fill_req_q, fill_req_d;
  logic [31:0]       hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  logic              hit, has_free, is_write, misaligned, line_we;
  logic [AGE_W-1:0]  hit_way, free_way, lru_way, acc_way;
  logic [AGE_W-1:0]  new_age [WAYS];
  logic [OFF_W-1:0]  align_mask;
  logic [OFF_W+2:0]  shift;
  logic [63:0]       wmask64, rd64;
  logic [LINE_W-1:0] base_line, line_mask, merged_line, rd_line;

  assign is_write   = (op_q == 2'd1);
  assign align_mask = OFF_W'((32'd1 << size_q) - 32'd1);
  assign misaligned = |(off_q & align_mask);
  assign shift      = {off_q, 3'b000};

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    lru_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w]) begin
        has_free = 1'b1;
        free_way = AGE_W'(w);
      end
      if (valid_q[w] && tag_q[w] == rtag_q) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    wmask64 = 64'h0000_0000_0000_00ff;
      2'd1:    wmask64 = 64'h0000_0000_0000_ffff;
      2'd2:    wmask64 = 64'h0000_0000_ffff_ffff;
      default: wmask64 = 64'hffff_ffff_ffff_ffff;
    endcase
  end

  // The accessed line is the hit way in LOOKUP or the incoming fill line in FILL.
  assign acc_way     = (state_q == FILL) ? victim_q : hit_way;
  assign base_line   = (state_q == FILL) ? fill_data : data_q[acc_way];
  assign line_mask   = LINE_W'(wmask64) << shift;
  assign merged_line = is_write ? ((base_line & ~line_mask) | (LINE_W'(wdata_q & wmask64) << shift))
                                : base_line;
  assign rd_line     = base_line >> shift;
  assign rd64        = rd_line[63:0] & wmask64;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == acc_way)            new_age[w] = '0;
      else if (age_q[w] < age_q[acc_way])  new_age[w] = age_q[w] + AGE_W'(1);
      else                                 new_age[w] = age_q[w];
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    age_d        = age_q;
    op_d         = op_q;
    rtag_d       = rtag_q;
    off_d        = off_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    wb_valid_d   = wb_valid_q;
    fill_req_d   = fill_req_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    resp_valid_d = 1'b0;
    hit_d        = 1'b0;
    err_d        = 1'b0;
    rdata_d      = '0;
    line_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !req_op[1]) begin
          op_d    = req_op;
          rtag_d  = req_tag;
          off_d   = req_offset;
          size_d  = req_size;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (misaligned) begin
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
          state_d      = RESP;
        end else if (hit) begin
          line_we          = is_write;
          dirty_d[hit_way] = dirty_q[hit_way] | is_write;
          age_d            = new_age;
          hit_count_d      = hit_count_q + 32'd1;
          resp_valid_d     = 1'b1;
          hit_d            = 1'b1;
          rdata_d          = is_write ? 64'd0 : rd64;
          state_d          = RESP;
        end else begin
          miss_count_d = miss_count_q + 32'd1;
          victim_d     = has_free ? free_way : lru_way;
          if (dirty_q[victim_d]) begin
            wb_valid_d = 1'b1;
            state_d    = EVICT;
          end else begin
            fill_req_d = 1'b1;
            state_d    = FILL;
          end
        end
      end
      EVICT: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          fill_req_d = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (fill_valid) begin
          fill_req_d        = 1'b0;
          line_we           = 1'b1;
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = is_write;
          tag_d[victim_q]   = rtag_q;
          age_d             = new_age;
          resp_valid_d      = 1'b1;
          rdata_d           = is_write ? 64'd0 : rd64;
          state_d           = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      for (int w = 0; w < WAYS; w++) begin
        tag_q[w] <= '0;
        age_q[w] <= AGE_W'(w);
      end
      op_q         <= '0;
      rtag_q       <= '0;
      off_q        <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      wb_valid_q   <= 1'b0;
      fill_req_q   <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      age_q        <= age_d;
      op_q         <= op_d;
      rtag_q       <= rtag_d;
      off_q        <= off_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      wb_valid_q   <= wb_valid_d;
      fill_req_q   <= fill_req_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Line storage carries no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (line_we) data_q[acc_way] <= merged_line;
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_hit   = hit_q;
  assign resp_err   = err_q;
  assign wb_valid   = wb_valid_q;
  assign wb_tag     = tag_q[victim_q];
  assign wb_data    = data_q[victim_q];
  assign fill_req   = fill_req_q;
  assign fill_tag   = rtag_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_cache_set_nway.sv
// tb/tb_cache_set_nway.sv - directed and random checks of cache_set_nway against a byte-level set model
module tb_cache_set_nway;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = '0;
  logic [23:0]  req_tag = '0;
  logic [5:0]   req_offset = '0;
  logic [1:0]   req_size = '0;
  logic [63:0]  req_wdata = '0;
  logic         resp_valid, resp_hit, resp_err;
  logic [63:0]  resp_rdata;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [23:0]  wb_tag;
  logic [511:0] wb_data;
  logic         fill_req;
  logic [23:0]  fill_tag;
  logic         fill_valid = 1'b0;
  logic [511:0] fill_data = '0;
  logic [31:0]  hit_count, miss_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   m_bytes [4][64];
  bit           m_valid [4];
  bit           m_dirty [4];
  logic [23:0]  m_tag [4];
  int           m_order [$];
  int unsigned  m_hits, m_misses;

  cache_set_nway #(.WAYS(4), .BLOCK_BYTES(64), .TAG_W(24)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_offset(req_offset), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit), .resp_err(resp_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
    .fill_req(fill_req), .fill_tag(fill_tag), .fill_valid(fill_valid), .fill_data(fill_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_order.delete();
    for (int w = 0; w < 4; w++) begin
      m_valid[w] = 0;
      m_dirty[w] = 0;
      m_order.push_back(w);
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  // Recency list, most recent first; the tail is the replacement candidate.
  function automatic void touch(input int w);
    int idx = 0;
    for (int i = 0; i < m_order.size(); i++) if (m_order[i] == w) idx = i;
    m_order.delete(idx);
    m_order.push_front(w);
  endfunction

  function automatic logic [511:0] line_of(input int w);
    logic [511:0] l = '0;
    for (int k = 0; k < 64; k++) l[8*k +: 8] = m_bytes[w][k];
    return l;
  endfunction

  function automatic logic [63:0] access(input int w, input logic [1:0] op, input int off,
                                         input int nb, input logic [63:0] wd);
    logic [63:0] rd = '0;
    touch(w);
    for (int k = 0; k < nb; k++) begin
      if (op == 2'd1) m_bytes[w][off+k] = wd[8*k +: 8];
      else rd[8*k +: 8] = m_bytes[w][off+k];
    end
    if (op == 2'd1) m_dirty[w] = 1;
    return rd;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic do_req(input logic [1:0] op, input logic [23:0] tag, input int off,
                        input logic [1:0] sz, input logic [63:0] wd, input int wb_hold,
                        input int fill_dly, input logic [511:0] fl);
    int nb, hw, v, budget;
    logic [63:0] exp_rd;
    logic [511:0] exp_line;
    nb = 1 << sz;
    hw = -1;
    for (int w = 0; w < 4; w++) if (m_valid[w] && m_tag[w] == tag) hw = w;
    budget = 0;
    while (!req_ready && budget < 50) begin
      tick();
      budget++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_tag = tag; req_offset = off[5:0]; req_size = sz; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    chk("busy_after_accept", req_ready, 0);
    tick();
    if ((off % nb) != 0) begin
      chk("err_valid", resp_valid, 1);
      chk("err_flag", resp_err, 1);
      chk("err_hit", resp_hit, 0);
      chk("err_no_fill", fill_req, 0);
    end else if (hw >= 0) begin
      exp_rd = access(hw, op, off, nb, wd);
      m_hits++;
      chk("hit_valid", resp_valid, 1);
      chk("hit_flag", resp_hit, 1);
      chk("hit_err", resp_err, 0);
      chk("hit_rdata", resp_rdata, exp_rd);
    end else begin
      m_misses++;
      v = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[w]) v = w;
      if (v < 0) v = m_order[$];
      chk("miss_no_resp", resp_valid, 0);
      if (m_dirty[v]) begin
        exp_line = line_of(v);
        for (int i = 0; i <= wb_hold; i++) begin
          chk("wb_valid", wb_valid, 1);
          chk("wb_tag", wb_tag, m_tag[v]);
          chk("wb_data", wb_data, exp_line);
          chk("wb_no_fill", fill_req, 0);
          chk("wb_busy", req_ready, 0);
          if (i < wb_hold) tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
      end
      chk("fill_no_wb", wb_valid, 0);
      for (int i = 0; i <= fill_dly; i++) begin
        chk("fill_req", fill_req, 1);
        chk("fill_tag", fill_tag, tag);
        if (i < fill_dly) tick();
      end
      fill_valid = 1'b1;
      fill_data = fl;
      tick();
      fill_valid = 1'b0;
      m_valid[v] = 1;
      m_dirty[v] = 0;
      m_tag[v] = tag;
      for (int k = 0; k < 64; k++) m_bytes[v][k] = fl[8*k +: 8];
      exp_rd = access(v, op, off, nb, wd);
      chk("fill_resp_valid", resp_valid, 1);
      chk("fill_resp_hit", resp_hit, 0);
      chk("fill_resp_err", resp_err, 0);
      chk("fill_rdata", resp_rdata, exp_rd);
      chk("fill_req_drop", fill_req, 0);
    end
    tick();
    chk("resp_pulse_end", resp_valid, 0);
    chk("ready_again", req_ready, 1);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
  endtask

  task automatic idle_pulses(input logic [1:0] op);
    req_valid = 1'b1; req_op = op; req_tag = 24'd16; req_offset = '0; req_size = 2'd3;
    tick();
    req_valid = 1'b0;
    chk("noop_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("noop_no_resp", resp_valid, 0);
      tick();
    end
    chk("noop_hits", hit_count, m_hits);
    chk("noop_misses", miss_count, m_misses);
  endtask

  initial begin
    int off, nb;
    logic [1:0] sz, op;
    m_reset();
    #3;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fill_req", fill_req, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    tick();
    rst = 1'b0;
    tick();

    do_req(2'd1, 24'd16, 0, 2'd0, 64'd3, 0, 1, '0);
    do_req(2'd0, 24'd16, 0, 2'd3, 64'd0, 0, 0, '0);
    chk("s1_hits", hit_count, 1);
    chk("s1_misses", miss_count, 1);

    do_req(2'd1, 24'd25, 8, 2'd2, 64'h1234_5678, 0, 0, rand_line());
    do_req(2'd0, 24'd30, 0, 2'd3, 64'd0, 0, 2, rand_line());
    do_req(2'd0, 24'd31, 0, 2'd1, 64'd0, 0, 0, rand_line());
    do_req(2'd0, 24'd16, 0, 2'd3, 64'd0, 0, 0, rand_line());
    do_req(2'd0, 24'd40, 16, 2'd3, 64'd0, 2, 1, rand_line());
    do_req(2'd0, 24'd25, 8, 2'd2, 64'd0, 0, 0, rand_line());
    chk("s2_hits", hit_count, 2);
    chk("s2_misses", miss_count, 6);

    do_req(2'd0, 24'd40, 2, 2'd2, 64'd0, 0, 0, rand_line());
    chk("s3_err_hits", hit_count, 2);
    chk("s3_err_misses", miss_count, 6);
    do_req(2'd0, 24'd40, 4, 2'd2, 64'd0, 0, 0, rand_line());

    for (int t = 50; t < 54; t++) do_req(2'd1, 24'(t), 8, 2'd3, {$urandom, $urandom}, 0, 0, rand_line());
    do_req(2'd0, 24'd54, 8, 2'd3, 64'd0, 5, 0, rand_line());

    do_req(2'd1, 24'd60, 0, 2'd0, 64'hab, 0, 0, rand_line());
    idle_pulses(2'd2);
    idle_pulses(2'd3);
    fill_valid = 1'b1; fill_data = rand_line();
    tick();
    fill_valid = 1'b0; wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("stray_no_resp", resp_valid, 0);
    chk("stray_no_fill", fill_req, 0);
    chk("stray_no_wb", wb_valid, 0);
    chk("stray_ready", req_ready, 1);
    do_req(2'd0, 24'd60, 0, 2'd3, 64'd0, 0, 0, rand_line());

    req_valid = 1'b1; req_op = 2'd0; req_tag = 24'd99; req_offset = '0; req_size = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    if (wb_valid) begin
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
    end
    chk("abort_in_fill", fill_req, 1);
    rst = 1'b1;
    #1;
    chk("abort_fill_drop", fill_req, 0);
    chk("abort_wb_drop", wb_valid, 0);
    chk("abort_no_resp", resp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_misses", miss_count, 0);
    tick();
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_no_resp", resp_valid, 0);
    end
    do_req(2'd0, 24'd16, 0, 2'd3, 64'd0, 0, 0, rand_line());
    chk("post_abort_miss", miss_count, 1);

    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      off = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) off = off - (off % nb);
      do_req(op, 24'(16 + $urandom_range(0, 6)), off, sz, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), rand_line());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
